// File: rtl/ysyx_25020047_pkg.sv
// ysyx_25020047_pkg
// Shared definitions for the load/store unit:
//   lsu_op_t     access type encoding driven by execute (LW, LBU, SW, SB)
//   lsu_state_t  LSU transaction FSM states
//   MASK_WORD    byte strobes for a full-word store
//   MASK_BYTE    byte strobe for lane 0, shifted by the address offset for SB
//   is_store()   true for the two store encodings
package ysyx_25020047_pkg;

    typedef enum logic [1:0] {
        LSU_LW  = 2'd0,
        LSU_LBU = 2'd1,
        LSU_SW  = 2'd2,
        LSU_SB  = 2'd3
    } lsu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_t;

    localparam logic [3:0] MASK_WORD = 4'hF;
    localparam logic [3:0] MASK_BYTE = 4'h1;

    function automatic logic is_store(input lsu_op_t op);
        return (op == LSU_SW) || (op == LSU_SB);
    endfunction

endpackage

// File: rtl/ysyx_25020047_lsu_align.sv
// ysyx_25020047_lsu_align
// Combinational lane formatting for the LSU.
//   op        access type (lsu_op_t encoding)
//   off       byte offset inside the word (addr[1:0])
//   wdata     raw store data (rs2)
//   rdata     raw word returned by memory
//   wmask     byte-lane strobes (zero for loads)
//   wdata_rep store data placed on every lane that the mask may select
//   load_data aligned, zero-extended load result (zero for stores)
module ysyx_25020047_lsu_align
    import ysyx_25020047_pkg::*;
(
    input  logic [1:0]  op,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wmask,
    output logic [31:0] wdata_rep,
    output logic [31:0] load_data
);

    logic [7:0] rbyte;

    // Pick the addressed byte lane out of the returned word.
    always_comb begin
        rbyte = rdata[7:0];
        case (off)
            2'd0:    rbyte = rdata[7:0];
            2'd1:    rbyte = rdata[15:8];
            2'd2:    rbyte = rdata[23:16];
            default: rbyte = rdata[31:24];
        endcase
    end

    // Byte stores replicate the byte on all lanes so the strobe alone
    // decides which lane memory actually writes.
    always_comb begin
        wmask     = 4'h0;
        wdata_rep = 32'h0;
        load_data = 32'h0;
        case (lsu_op_t'(op))
            LSU_LW:  load_data = rdata;
            LSU_LBU: load_data = {24'h0, rbyte};
            LSU_SW: begin
                wmask     = MASK_WORD;
                wdata_rep = wdata;
            end
            default: begin
                wmask     = MASK_BYTE << off;
                wdata_rep = {4{wdata[7:0]}};
            end
        endcase
    end

endmodule

// File: rtl/ysyx_25020047_lsu.sv
// ysyx_25020047_lsu
// Load/store unit between execute and writeback. Accepts one access at a
// time, runs a request/response transaction on a word-wide memory port and
// holds the formatted result for writeback until it is consumed.
//   clk, rst                      clock, asynchronous active-high reset
//   in_valid/in_ready             access handshake from execute
//   in_op/in_addr/in_wdata/in_wen access type, address, store data, rd write enable
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_wmask           memory request channel (held until mem_gnt)
//   mem_gnt                       request accepted
//   mem_rvalid/mem_rdata          memory response (read data or write done)
//   out_valid/out_ready           result handshake to writeback
//   out_data/out_wen/out_fault    load data, rd write enable, misalignment fault
// Optional feature macro: YSYX_25020047_LSU_MISALIGN_CHECK_EN makes misaligned
// LW/SW fault instead of silently accessing the containing word.
module ysyx_25020047_lsu
    import ysyx_25020047_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_op,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic        in_wen,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_wen,
    output logic        out_fault
);

    lsu_state_t  state_q, state_d;
    lsu_op_t     op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        wen_q, wen_d;
    logic [31:0] data_q, data_d;
    logic        out_wen_q, out_wen_d;
    logic        fault_q, fault_d;
    logic        in_ready_q, in_ready_d;
    logic        mem_req_q, mem_req_d;
    logic        out_valid_q, out_valid_d;

    logic        misaligned;
    logic [3:0]  fmt_wmask;
    logic [31:0] fmt_wdata;
    logic [31:0] fmt_load;

    ysyx_25020047_lsu_align u_align (
        .op        (op_q),
        .off       (addr_q[1:0]),
        .wdata     (wdata_q),
        .rdata     (mem_rdata),
        .wmask     (fmt_wmask),
        .wdata_rep (fmt_wdata),
        .load_data (fmt_load)
    );

`ifdef YSYX_25020047_LSU_MISALIGN_CHECK_EN
    // Only word accesses can be misaligned; byte accesses fit any offset.
    assign misaligned = ((lsu_op_t'(in_op) == LSU_LW) || (lsu_op_t'(in_op) == LSU_SW))
                        && (in_addr[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // Next-state logic. Handshake outputs are derived from the next state so
    // they come straight out of flops and track the FSM without a cycle lag.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wen_d     = wen_q;
        data_d    = data_q;
        out_wen_d = out_wen_q;
        fault_d   = fault_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    op_d    = lsu_op_t'(in_op);
                    addr_d  = in_addr;
                    wdata_d = in_wdata;
                    wen_d   = in_wen;
                    if (misaligned) begin
                        state_d   = ST_RESP;
                        data_d    = 32'h0;
                        out_wen_d = 1'b0;
                        fault_d   = 1'b1;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            // A response seen together with the grant is not the response to
            // this request, so REQ looks only at mem_gnt.
            ST_REQ: begin
                if (mem_gnt) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid) begin
                    state_d   = ST_RESP;
                    data_d    = fmt_load;
                    out_wen_d = wen_q && !is_store(op_q);
                    fault_d   = 1'b0;
                end
            end
            default: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
        in_ready_d  = (state_d == ST_IDLE);
        mem_req_d   = (state_d == ST_REQ);
        out_valid_d = (state_d == ST_RESP);
    end

    // Reset drops mem_req/out_valid immediately, abandoning any transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= LSU_LW;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            wen_q       <= 1'b0;
            data_q      <= 32'h0;
            out_wen_q   <= 1'b0;
            fault_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            mem_req_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wen_q       <= wen_d;
            data_q      <= data_d;
            out_wen_q   <= out_wen_d;
            fault_q     <= fault_d;
            in_ready_q  <= in_ready_d;
            mem_req_q   <= mem_req_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Request and result buses are qualified by their valids so they read
    // zero whenever nothing is being offered.
    assign in_ready  = in_ready_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_req_q && is_store(op_q);
    assign mem_addr  = mem_req_q ? {addr_q[31:2], 2'b00} : 32'h0;
    assign mem_wdata = mem_req_q ? fmt_wdata : 32'h0;
    assign mem_wmask = mem_req_q ? fmt_wmask : 4'h0;
    assign out_valid = out_valid_q;
    assign out_data  = out_valid_q ? data_q : 32'h0;
    assign out_wen   = out_valid_q && out_wen_q;
    assign out_fault = out_valid_q && fault_q;

endmodule

// File: tb/tb_ysyx_25020047_lsu.sv
// tb_ysyx_25020047_lsu
// Directed self-checking bench for ysyx_25020047_lsu. Drives execute,
// memory and writeback sides by hand, one clock at a time, and compares the
// DUT outputs against hand-computed expected values.
module tb_ysyx_25020047_lsu;
    import ysyx_25020047_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic        in_wen;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_wen;
    logic        out_fault;

    int num_checks = 0;
    int num_pass   = 0;

    ysyx_25020047_lsu dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_addr    (in_addr),
        .in_wdata   (in_wdata),
        .in_wen     (in_wen),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wmask  (mem_wmask),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_wen    (out_wen),
        .out_fault  (out_fault)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle and land 1 ns past the rising edge, where inputs
    // are driven and registered outputs are sampled.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single comparison point: counts the check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        num_checks++;
        if (actual === expected) begin
            num_pass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Offer one access from execute for exactly one cycle (the accept cycle).
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic wen, input string tag);
        checkOutput({tag, "_in_ready_idle"}, {31'h0, in_ready}, 32'h1);
        in_valid = 1'b1;
        in_op    = op;
        in_addr  = addr;
        in_wdata = wdata;
        in_wen   = wen;
        step();
        in_valid = 1'b0;
        in_op    = 2'd0;
        in_addr  = 32'h0;
        in_wdata = 32'h0;
        in_wen   = 1'b0;
    endtask

    // Full transaction: grant after gnt_delay REQ cycles, response one cycle
    // later, writeback ready after rdy_delay RESP cycles. A bogus response is
    // driven throughout REQ (including the grant cycle) and must be ignored.
    task automatic doAccess(input logic [1:0] op, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic wen,
                            input logic [31:0] rdata, input int gnt_delay,
                            input int rdy_delay, input logic [31:0] exp_addr,
                            input logic [3:0] exp_mask, input logic [31:0] exp_wdata,
                            input logic [31:0] exp_data, input logic exp_wen,
                            input string tag);
        logic exp_we;
        exp_we = op[1];
        applyStimulus(op, addr, wdata, wen, tag);
        for (int g = 0; g <= gnt_delay; g++) begin
            checkOutput({tag, "_mem_req"}, {31'h0, mem_req}, 32'h1);
            checkOutput({tag, "_mem_addr"}, mem_addr, exp_addr);
            checkOutput({tag, "_mem_we"}, {31'h0, mem_we}, {31'h0, exp_we});
            checkOutput({tag, "_mem_wmask"}, {28'h0, mem_wmask}, {28'h0, exp_mask});
            if (exp_we) begin
                checkOutput({tag, "_mem_wdata"}, mem_wdata, exp_wdata);
            end
            checkOutput({tag, "_in_ready_busy"}, {31'h0, in_ready}, 32'h0);
            mem_rvalid = 1'b1;
            mem_rdata  = ~rdata;
            mem_gnt    = (g == gnt_delay);
            step();
        end
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        checkOutput({tag, "_wait_req"}, {31'h0, mem_req}, 32'h0);
        checkOutput({tag, "_wait_valid"}, {31'h0, out_valid}, 32'h0);
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        step();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        for (int r = 0; r <= rdy_delay; r++) begin
            checkOutput({tag, "_out_valid"}, {31'h0, out_valid}, 32'h1);
            checkOutput({tag, "_out_data"}, out_data, exp_data);
            checkOutput({tag, "_out_wen"}, {31'h0, out_wen}, {31'h0, exp_wen});
            checkOutput({tag, "_out_fault"}, {31'h0, out_fault}, 32'h0);
            checkOutput({tag, "_resp_in_ready"}, {31'h0, in_ready}, 32'h0);
            out_ready = (r == rdy_delay);
            step();
        end
        out_ready = 1'b0;
        checkOutput({tag, "_done_valid"}, {31'h0, out_valid}, 32'h0);
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_op      = 2'd0;
        in_addr    = 32'h0;
        in_wdata   = 32'h0;
        in_wen     = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        out_ready  = 1'b0;

        #2;
        checkOutput("rst_in_ready", {31'h0, in_ready}, 32'h1);
        checkOutput("rst_mem_req", {31'h0, mem_req}, 32'h0);
        checkOutput("rst_mem_we", {31'h0, mem_we}, 32'h0);
        checkOutput("rst_mem_addr", mem_addr, 32'h0);
        checkOutput("rst_mem_wdata", mem_wdata, 32'h0);
        checkOutput("rst_mem_wmask", {28'h0, mem_wmask}, 32'h0);
        checkOutput("rst_out_valid", {31'h0, out_valid}, 32'h0);
        checkOutput("rst_out_data", out_data, 32'h0);
        checkOutput("rst_out_wen", {31'h0, out_wen}, 32'h0);
        checkOutput("rst_out_fault", {31'h0, out_fault}, 32'h0);
        step();
        rst = 1'b0;
        step();

        $display("[TB] minimum-latency accesses");
        doAccess(LSU_LW, 32'h8000_0010, 32'h0, 1'b1, 32'hDEAD_BEEF, 0, 0,
                 32'h8000_0010, 4'h0, 32'h0, 32'hDEAD_BEEF, 1'b1, "lw");
        doAccess(LSU_LBU, 32'h8000_0013, 32'h0, 1'b1, 32'hA1B2_C3D4, 0, 0,
                 32'h8000_0010, 4'h0, 32'h0, 32'h0000_00A1, 1'b1, "lbu3");
        doAccess(LSU_SB, 32'h8000_0002, 32'h1234_5678, 1'b1, 32'h0, 0, 0,
                 32'h8000_0000, 4'b0100, 32'h7878_7878, 32'h0, 1'b0, "sb2");
        doAccess(LSU_LBU, 32'h8000_0101, 32'h0, 1'b0, 32'h1122_3344, 0, 0,
                 32'h8000_0100, 4'h0, 32'h0, 32'h0000_0033, 1'b0, "lbu1_nowen");
        doAccess(LSU_SW, 32'h8000_0040, 32'hCAFE_BABE, 1'b1, 32'h0, 0, 0,
                 32'h8000_0040, 4'hF, 32'hCAFE_BABE, 32'h0, 1'b0, "sw");
        doAccess(LSU_SB, 32'h8000_0003, 32'h0000_00AB, 1'b1, 32'h0, 0, 0,
                 32'h8000_0000, 4'b1000, 32'hABAB_ABAB, 32'h0, 1'b0, "sb3");

        $display("[TB] stalled grant and stalled writeback");
        doAccess(LSU_LW, 32'h8000_0020, 32'h0, 1'b1, 32'h0BAD_F00D, 3, 2,
                 32'h8000_0020, 4'h0, 32'h0, 32'h0BAD_F00D, 1'b1, "lw_stall");

        $display("[TB] reset during REQ");
        applyStimulus(LSU_LW, 32'h8000_0050, 32'h0, 1'b1, "rst_req");
        checkOutput("rst_req_before", {31'h0, mem_req}, 32'h1);
        #3 rst = 1'b1;
        #1;
        checkOutput("rst_req_mem_req", {31'h0, mem_req}, 32'h0);
        checkOutput("rst_req_in_ready", {31'h0, in_ready}, 32'h1);
        checkOutput("rst_req_mem_addr", mem_addr, 32'h0);
        #2 rst = 1'b0;
        step();

        $display("[TB] reset during WAIT");
        applyStimulus(LSU_LW, 32'h8000_0060, 32'h0, 1'b1, "rst_wait");
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        checkOutput("rst_wait_before", {31'h0, in_ready}, 32'h0);
        #3 rst = 1'b1;
        #1;
        checkOutput("rst_wait_mem_req", {31'h0, mem_req}, 32'h0);
        checkOutput("rst_wait_out_valid", {31'h0, out_valid}, 32'h0);
        checkOutput("rst_wait_in_ready", {31'h0, in_ready}, 32'h1);
        #2 rst = 1'b0;
        step();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5555_AAAA;
        step();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        checkOutput("late_rvalid_out_valid", {31'h0, out_valid}, 32'h0);
        checkOutput("late_rvalid_in_ready", {31'h0, in_ready}, 32'h1);
        step();
        checkOutput("late_rvalid_out_valid2", {31'h0, out_valid}, 32'h0);

        $display("[TB] misaligned word store");
`ifdef YSYX_25020047_LSU_MISALIGN_CHECK_EN
        applyStimulus(LSU_SW, 32'h8000_0001, 32'hCAFE_F00D, 1'b1, "mis_sw");
        checkOutput("mis_sw_mem_req", {31'h0, mem_req}, 32'h0);
        checkOutput("mis_sw_out_valid", {31'h0, out_valid}, 32'h1);
        checkOutput("mis_sw_out_fault", {31'h0, out_fault}, 32'h1);
        checkOutput("mis_sw_out_data", out_data, 32'h0);
        checkOutput("mis_sw_out_wen", {31'h0, out_wen}, 32'h0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checkOutput("mis_sw_done", {31'h0, out_valid}, 32'h0);
        checkOutput("mis_sw_mem_req_after", {31'h0, mem_req}, 32'h0);
`else
        doAccess(LSU_SW, 32'h8000_0001, 32'hCAFE_F00D, 1'b1, 32'h0, 0, 0,
                 32'h8000_0000, 4'hF, 32'hCAFE_F00D, 32'h0, 1'b0, "mis_sw");
`endif

        $display("%0d/%0d checks passed", num_pass, num_checks);
        $finish;
    end

endmodule
